// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one 8-bit ALU among N_REQ requesters.
// The winning request's result, carry and ID are captured in a single response
// register that holds under rsp_ready backpressure. The alu module lives here too.
// Optional feature macro: ALU_SCHED_DIV0_EN
//   Defined:   a divide by zero returns 8'hFF with rsp_err=1.
//   Undefined: rsp_err is tied to 0.
//
// alu_sel encoding:
//   0000 add   0001 sub   0010 mul   0011 div
//   0100 shl1  0101 shr1  0110 rol1  0111 ror1
//   1000 and   1001 or    1010 xor   1011 nor
//   1100 nand  1101 xnor  1110 a>b   1111 a==b
// cout is always the carry of a+b, whatever the opcode.

module alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] alu_sel,
  output logic [7:0] alu_out,
  output logic       cout
);

  logic [8:0] sum;

  // Opcode decode plus the add carry, which is reported for every opcode
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    cout = sum[8];
    case (alu_sel)
      4'b0000: alu_out = sum[7:0];
      4'b0001: alu_out = a - b;
      4'b0010: alu_out = a * b;
      4'b0011: alu_out = a / b;
      4'b0100: alu_out = {a[6:0], 1'b0};
      4'b0101: alu_out = {1'b0, a[7:1]};
      4'b0110: alu_out = {a[6:0], a[7]};
      4'b0111: alu_out = {a[0], a[7:1]};
      4'b1000: alu_out = a & b;
      4'b1001: alu_out = a | b;
      4'b1010: alu_out = a ^ b;
      4'b1011: alu_out = ~(a | b);
      4'b1100: alu_out = ~(a & b);
      4'b1101: alu_out = ~(a ^ b);
      4'b1110: alu_out = {7'b0, (a > b)};
      default: alu_out = {7'b0, (a == b)};
    endcase
  end

endmodule

module alu_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [4*N_REQ-1:0]   req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_cout,
  output logic                 rsp_err
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [7:0]      alu_a, alu_b, alu_y;
  logic [3:0]      alu_op;
  logic            alu_cout;
  logic            can_accept;
  logic            accept;

  // Round-robin search starting one past the last grant; the winner's operands feed the ALU
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = 4'h0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
        alu_a     = req_a[8*idx +: 8];
        alu_b     = req_b[8*idx +: 8];
        alu_op    = req_sel[4*idx +: 4];
      end
    end
  end

  alu u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .alu_sel (alu_op),
    .alu_out (alu_y),
    .cout    (alu_cout)
  );

  // One-hot ready for the winner, suppressed while the response register is stalled or in reset
  always_comb begin
    can_accept = (state_q == S_EMPTY) || rsp_ready;
    req_ready  = '0;
    if (rst_n && can_accept && gnt_found)
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
    accept = |req_ready;
  end

  // Response-register FSM and next-state data: load on accept, drain on rsp_ready, else hold
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      default: begin
        if (accept)         state_d = S_FULL;
        else if (rsp_ready) state_d = S_EMPTY;
      end
    endcase
    if (accept) begin
      last_grant_d = gnt_id;
      rsp_id_d     = gnt_id;
      rsp_data_d   = alu_y;
      rsp_cout_d   = alu_cout;
      rsp_err_d    = 1'b0;
`ifdef ALU_SCHED_DIV0_EN
      if (alu_op == 4'b0011 && alu_b == 8'h00) begin
        rsp_data_d = 8'hFF;
        rsp_err_d  = 1'b1;
      end
`endif
    end
  end

  // State and response register; last_grant resets to N_REQ-1 so port 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      last_grant_q <= ID_W'(N_REQ-1);
      rsp_id_q     <= '0;
      rsp_data_q   <= 8'h00;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ALU_SCHED_DIV0_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a scoreboard of expected responses.
// Expected responses come from a reference ALU and round-robin model in this file.
`timescale 1ns/1ps

module tb_alu_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [4*N-1:0] req_sel;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           rsp_cout;
  logic           rsp_err;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       cout;
    logic       err;
  } rsp_t;

  rsp_t       sb_q[$];
  rsp_t       m_cur;
  logic       m_valid;
  logic [1:0] m_last;
  int         n_asserts = 0;
  int         n_fail    = 0;

  alu_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic rsp_t ref_alu(input logic [1:0] id, input logic [7:0] a,
                                   input logic [7:0] b, input logic [3:0] s);
    rsp_t       r;
    logic [8:0] sum;
    logic [15:0] p;
    sum    = {1'b0, a} + {1'b0, b};
    p      = {8'h00, a} * {8'h00, b};
    r.id   = id;
    r.cout = sum[8];
    r.err  = 1'b0;
    case (s)
      4'h0: r.data = sum[7:0];
      4'h1: r.data = a - b;
      4'h2: r.data = p[7:0];
      4'h3: begin
        if (b == 8'h00) begin
          r.data = 8'hFF;
          r.err  = 1'b1;
        end else begin
          r.data = a / b;
        end
      end
      4'h4: r.data = {a[6:0], 1'b0};
      4'h5: r.data = {1'b0, a[7:1]};
      4'h6: r.data = {a[6:0], a[7]};
      4'h7: r.data = {a[0], a[7:1]};
      4'h8: r.data = a & b;
      4'h9: r.data = a | b;
      4'hA: r.data = a ^ b;
      4'hB: r.data = ~(a | b);
      4'hC: r.data = ~(a & b);
      4'hD: r.data = ~(a ^ b);
      4'hE: r.data = (a > b) ? 8'h01 : 8'h00;
      default: r.data = (a == b) ? 8'h01 : 8'h00;
    endcase
    return r;
  endfunction

  task automatic set_op(input int p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    req_a[8*p +: 8]   = a;
    req_b[8*p +: 8]   = b;
    req_sel[4*p +: 4] = s;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = 2'd3;
    m_cur   = '0;
    sb_q.delete();
  endtask

  // One clock cycle: entered just after a rising edge, leaves just after the next one.
  task automatic step(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] exp_rdy;
    logic         found;
    logic [1:0]   g;
    rsp_t         popped;
    req_valid = v;
    rsp_ready = rr;
    #1;
    found = 1'b0;
    g     = 2'd0;
    for (int k = 1; k <= N; k++) begin
      logic [1:0] idx;
      idx = m_last + 2'(k);
      if (!found && v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    exp_rdy = '0;
    if ((!m_valid || rr) && found) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      sb_q.push_back(ref_alu(g, req_a[8*g +: 8], req_b[8*g +: 8], req_sel[4*g +: 4]));
      m_last  = g;
      m_valid = 1'b1;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (sb_q.size() != 0) begin
      popped = sb_q.pop_front();
      m_cur  = popped;
    end
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_cur.id));
      chk("rsp_data", 32'(rsp_data), 32'(m_cur.data));
      chk("rsp_cout", 32'(rsp_cout), 32'(m_cur.cout));
      chk("rsp_err", 32'(rsp_err), 32'(m_cur.err));
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [3:0] rs;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    model_reset();

    // Reset state, with requests pending so ready gating by reset is visible
    repeat (2) @(posedge clk);
    req_valid = 4'hF;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_rsp_cout", 32'(rsp_cout), 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset release
    repeat (2) step(4'h0, 1'b1);
    chk("idle_rsp_data", 32'(rsp_data), 32'h0);

    // All ports valid: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < N; p++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rs = 4'($urandom);
        if (rs == 4'h3 && rb == 8'h00) rb = 8'h01;
        set_op(p, ra, rb, rs);
      end
      step(4'hF, 1'b1);
      chk("rr_order_id", 32'(rsp_id), 32'(i % N));
    end
    step(4'h0, 1'b1);

    // Single request on port 2: F0+20
    set_op(2, 8'hF0, 8'h20, 4'b0000);
    step(4'b0100, 1'b1);
    chk("p2_add_id", 32'(rsp_id), 32'd2);
    chk("p2_add_data", 32'(rsp_data), 32'h10);
    chk("p2_add_cout", 32'(rsp_cout), 32'h1);
    step(4'h0, 1'b1);
    chk("p2_drain_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: accept port 1 (3*5), stall three cycles, then port 2 is next
    set_op(1, 8'h03, 8'h05, 4'b0010);
    set_op(2, 8'h11, 8'h22, 4'b0001);
    step(4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_op(1, 8'($urandom), 8'($urandom), 4'b0000);
      step(4'b0110, 1'b0);
      chk("bp_hold_data", 32'(rsp_data), 32'h0F);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
    end
    set_op(1, 8'h03, 8'h05, 4'b0010);
    step(4'b0110, 1'b1);
    chk("bp_release_id", 32'(rsp_id), 32'd2);
    step(4'h0, 1'b1);

`ifdef ALU_SCHED_DIV0_EN
    // Divide-by-zero substitution on port 0, then a legal divide
    set_op(0, 8'h40, 8'h00, 4'b0011);
    step(4'b0001, 1'b1);
    chk("div0_data", 32'(rsp_data), 32'hFF);
    chk("div0_err", 32'(rsp_err), 32'h1);
    set_op(0, 8'h40, 8'h04, 4'b0011);
    step(4'b0001, 1'b1);
    chk("div_data", 32'(rsp_data), 32'h10);
    chk("div_err", 32'(rsp_err), 32'h0);
    step(4'h0, 1'b1);
`endif

    // A few mixed opcodes with sparse valids and random backpressure
    for (int i = 0; i < 12; i++) begin
      for (int p = 0; p < N; p++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rs = 4'($urandom);
        if (rs == 4'h3 && rb == 8'h00) rb = 8'h07;
        set_op(p, ra, rb, rs);
      end
      step(4'($urandom), 1'($urandom));
    end
    step(4'h0, 1'b1);

    // Asynchronous reset while a response is stalled
    set_op(3, 8'h12, 8'h34, 4'b1000);
    step(4'b1000, 1'b1);
    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    chk("pre_areset_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(rsp_valid), 32'h0);
    chk("areset_data", 32'(rsp_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int p = 0; p < N; p++) set_op(p, 8'(p + 1), 8'h02, 4'b0000);
    step(4'hF, 1'b1);
    chk("post_reset_first_id", 32'(rsp_id), 32'd0);
    chk("post_reset_first_data", 32'(rsp_data), 32'h03);
    step(4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one 8-bit `alu` instance among `N_REQ` requesters. It arbitrates valid/ready requests and drives the selected operands and opcode into the ALU. It captures the result, carry and requester ID in a single output register, held under response backpressure. It sits between the requesting engines and the shared ALU datapath, and the ALU itself is instantiated inside this block.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default 2: requester ID width; must satisfy 2**`ID_W` >= `N_REQ`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept; at most one bit high.
- `req_a` in 8*`N_REQ`: operand a; requester i uses bits [8i+7:8i].
- `req_b` in 8*`N_REQ`: operand b; same packing as `req_a`.
- `req_sel` in 4*`N_REQ`: ALU opcode, using the `alu_sel` encoding; requester i uses bits [4i+3:4i].
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `ID_W`: index of the requester that owns the response.
- `rsp_data` out 8: ALU result.
- `rsp_cout` out 1: ALU carry-out, which is the carry of a+b regardless of opcode.
- `rsp_err` out 1: divide-by-zero flag; see Configuration.

## Operation
- `can_accept` = !`rsp_valid` || `rsp_ready`.
- Grant:
  - Round-robin search over `req_valid`, starting at `last_grant`+1 modulo `N_REQ`.
  - The first asserted index wins.
  - `req_ready[g]` = `can_accept` && `req_valid[g]`. All other bits are 0.
- `req_ready` is combinational from `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Accept is the condition `req_valid[g]` && `req_ready[g]`. On accept:
  - The mux drives `req_a`/`req_b`/`req_sel` slice g into the ALU.
  - At the clock edge, the ALU output, `cout`, g and the error flag load into the response register.
  - `rsp_valid` is set to 1.
  - `last_grant` is set to g.
- No accept while `can_accept` is true: `rsp_valid` falls to 0 if `rsp_ready` was high. `last_grant` is unchanged.
- While `rsp_valid`=1 and `rsp_ready`=0, `rsp_*` is held stable and no requester is granted.
- Fairness: a requester that holds `req_valid` high is granted within `N_REQ` accepts.
- Response-register states:
  - EMPTY to FULL on accept.
  - FULL to FULL on accept with `rsp_ready` (back-to-back).
  - FULL to EMPTY on `rsp_ready` with no accept.
- Requester inputs are sampled only in the cycle they are accepted. Operands may change after the handshake.
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=8'h00, `rsp_cout`=0, `rsp_err`=0.
  - `last_grant`=`N_REQ`-1, so port 0 has first priority.
  - `req_ready` is all zeros while `rst_n`=0.
- Reset mid-operation discards a pending response. A request accepted in the same cycle as reset assertion is lost, and requesters must reissue it.

## Timing
- Latency: a request accepted at edge k appears on `rsp_*` with `rsp_valid`=1 immediately after edge k. That is 1 cycle.
- Throughput: 1 response per cycle while `rsp_ready` is held high and any `req_valid` is set.
- Combinational paths:
  - `req_valid`/`rsp_ready` to `req_ready`.
  - `req_*` to the ALU to the response register D inputs.
- There is no path from inputs to `rsp_*`.

## Configuration
- `ALU_SCHED_DIV0_EN` defined:
  - A granted request with `req_sel`=4'b0011 and b=8'h00 loads `rsp_data`=8'hFF, `rsp_err`=1 and `rsp_cout`=ALU `cout`.
  - The ALU quotient is ignored in this case.
  - All other requests load `rsp_err`=0.
- `ALU_SCHED_DIV0_EN` undefined:
  - `rsp_err` is tied to 0.
  - Division by zero returns the raw ALU output, which is undefined.
  - Software must not issue division by zero.

## Test plan
- Reset, then idle: `req_ready`=0, `rsp_valid`=0, all `rsp_*`=0. Then assert `rst_n` with no requests: outputs stay 0.
- Single request on port 2 with a=8'hF0, b=8'h20, sel=0000 and `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_data`=8'h10, `rsp_cout`=1. The following cycle `rsp_valid`=0.
- All 4 ports valid continuously with `rsp_ready`=1 → grant order 0,1,2,3,0,…, one response per cycle with `rsp_id` matching that order.
- Backpressure: accept on port 1 (a=8'h03, b=8'h05, sel=0010), then hold `rsp_ready`=0 for 3 cycles → `rsp_data`=8'h0F held stable and `req_ready`=0 throughout. On release, the next grant goes to port 2 if valid.
- With `ALU_SCHED_DIV0_EN`: port 0 sends a=8'h40, b=8'h00, sel=0011 → `rsp_data`=8'hFF, `rsp_err`=1. Then a=8'h40, b=8'h04 → `rsp_data`=8'h10, `rsp_err`=0.
- Assert `rst_n`=0 while `rsp_valid`=1 and `rsp_ready`=0 → `rsp_valid` is 0 immediately (asynchronously). After release, port 0 wins first.
